multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle MIPS control unit: a Moore FSM that sequences each instruction through fetch/decode/execute/memory/writeback and drives the 4-bit ALU operation code directly into the ALU. It sits immediately upstream of the ALU and consumes the ALU `zero` flag for branch resolution. It also produces every datapath enable and mux select for PC, memory, instruction register and register file.

## Interface
- No parameters; widths fixed (opcode 6, funct 6, ALU op 4, state 4).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  IR[31:26], stable from DECODE onward.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag, same cycle.
- `aluOp`  out  4  ALU op: and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100.
- `aluSrcA`  out  1  0=PC, 1=regA.
- `aluSrcB`  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2.
- `pcEn`  out  1  PC load enable.
- `pcSource`  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- `iorD`  out  1  memory address: 0=PC, 1=ALUOut.
- `memRead`, `memWrite`, `irWrite`, `regWrite`  out  1 each  strobes.
- `regDst`  out  1  0=rt, 1=rd.
- `memToReg`  out  1  0=ALUOut, 1=MDR.
- `illegalOp`  out  1  one-cycle pulse in DECODE for unsupported opcode.
- `state`  out  4  current state, debug.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- FETCH: memRead, irWrite, iorD=0, srcA=0, srcB=01, aluOp add, pcSource 00, pcEn=1 -> DECODE.
- DECODE: srcA=0, srcB=11, aluOp add (branch target into ALUOut). Dispatch on opcode: 000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; other -> FETCH with illegalOp=1 (nop).
- MEMADR: srcA=1, srcB=10, add -> MEMRD if lw else MEMWR.
- MEMRD: memRead, iorD=1 -> MEMWB. MEMWB: regWrite, regDst=0, memToReg=1 -> FETCH.
- MEMWR: memWrite, iorD=1 -> FETCH.
- EXEC: srcA=1, srcB=00, aluOp from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor, other -> add -> RWB.
- RWB: regWrite, regDst=1, memToReg=0 -> FETCH.
- BRANCH: srcA=1, srcB=00, aluOp sub, pcSource 01, pcEn=zero -> FETCH.
- JUMP: pcSource 10, pcEn=1 -> FETCH.
- ADDIEX: srcA=1, srcB=10, add -> ADDIWB. ADDIWB: regWrite, regDst=0, memToReg=0 -> FETCH.
- States not listed as asserting a signal drive it 0; aluOp defaults to add (0010); unused encodings 12-15 -> FETCH next cycle, all strobes 0.

## Timing
- Outputs combinational from state register (plus funct in EXEC, zero in BRANCH); one state per cycle.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset: sampled at rising edge; next state FETCH. While reset=1, pcEn, memRead, memWrite, irWrite, regWrite, illegalOp forced 0 regardless of state.
- Reset mid-instruction: instruction abandoned, no write strobe in the reset cycle, FETCH on the first cycle after release.
- BRANCH with zero toggling within cycle: only the value settled at the clock edge matters.

## Structure
- Shared package `mips_pkg`: state encodings, opcode constants, funct constants, ALU op constants (shared with the ALU and its decode).
- One sub-module: `alu_decoder` (combinational funct -> 4-bit aluOp, default add), instantiated for EXEC.

## Test plan
- Reset held 3 cycles from state 5 -> all strobes 0 throughout; state=0 with pcEn=1, irWrite=1 on first post-reset cycle.
- opcode 100011 -> states 0,1,2,3,4,0; memRead in 0 and 3; regWrite only in 4 with memToReg=1, regDst=0.
- opcode 000000, funct 101010 -> states 0,1,6,7; aluOp=0111 in 6; regWrite, regDst=1 in 7. Repeat for each funct; funct 111111 -> aluOp 0010.
- opcode 000100 with zero=1 -> pcEn=1, pcSource=01 in state 8; with zero=0 -> pcEn=0; both return to 0 after 3 cycles.
- opcode 101011 -> states 0,1,2,5; memWrite=1, iorD=1 only in 5; opcode 000010 -> pcEn=1, pcSource=10 in 9.
- opcode 111111 -> illegalOp=1 for one cycle in state 1, next state 0, no regWrite/memWrite.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// R-type funct codes, ALU operation codes and datapath mux selects.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to 4-bit ALU operation; anything unrecognised adds.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_op
);

    always_comb begin
        o_alu_op = ALU_ADD;
        case (i_funct)
            FUNCT_ADD: o_alu_op = ALU_ADD;
            FUNCT_SUB: o_alu_op = ALU_SUB;
            FUNCT_AND: o_alu_op = ALU_AND;
            FUNCT_OR:  o_alu_op = ALU_OR;
            FUNCT_SLT: o_alu_op = ALU_SLT;
            FUNCT_NOR: o_alu_op = ALU_NOR;
            default:   o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multicycle MIPS datapath: one state per cycle, all
// enables and mux selects decoded from the state register.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] aluOp,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       pcEn,
    output logic [1:0] pcSource,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       illegalOp,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_funct_op;
    logic       w_pc_en;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;

    alu_decoder u_alu_decoder (
        .i_funct  (funct),
        .o_alu_op (w_funct_op)
    );

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        // NOTE: defaults first; any output missed by a branch would become a latch.
        w_next      = S_FETCH;
        aluOp       = ALU_ADD;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_REGB;
        pcSource    = PCSRC_ALU;
        iorD        = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        w_pc_en     = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_ir_write = 1'b1;
                aluSrcB    = SRCB_FOUR;
                w_pc_en    = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut while dispatching.
                aluSrcB = SRCB_IMMSH2;
                case (opcode)
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                iorD       = 1'b1;
                w_next     = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                memToReg    = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                iorD        = 1'b1;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = w_funct_op;
                w_next  = S_RWB;
            end
            S_RWB: begin
                w_reg_write = 1'b1;
                regDst      = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA  = 1'b1;
                aluOp    = ALU_SUB;
                pcSource = PCSRC_ALUOUT;
                w_pc_en  = zero;
            end
            S_JUMP: begin
                pcSource = PCSRC_JUMP;
                w_pc_en  = 1'b1;
            end
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset masks every architectural side effect, whatever state is held.
    assign pcEn      = w_pc_en     & ~reset;
    assign memRead   = w_mem_read  & ~reset;
    assign memWrite  = w_mem_write & ~reset;
    assign irWrite   = w_ir_write  & ~reset;
    assign regWrite  = w_reg_write & ~reset;
    assign illegalOp = w_illegal   & ~reset;
    assign state     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: a per-state model pushes expected outputs for each
// instruction into a scoreboard, which is drained one DUT cycle at a time.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       pcEn;
    logic [1:0] pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       illegalOp;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } obs_t;

    obs_t sb[$];

    multicycle_control dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .aluOp     (aluOp),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .pcEn      (pcEn),
        .pcSource  (pcSource),
        .iorD      (iorD),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .irWrite   (irWrite),
        .regWrite  (regWrite),
        .regDst    (regDst),
        .memToReg  (memToReg),
        .illegalOp (illegalOp),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o = '{state, aluOp, aluSrcA, aluSrcB, pcEn, pcSource, iorD, memRead,
              memWrite, irWrite, regWrite, regDst, memToReg, illegalOp};
        return o;
    endfunction

    // Reference behaviour of each state written from the instruction-level description.
    function automatic obs_t model(int st, logic [5:0] op, logic [5:0] fn, logic z);
        obs_t e;
        e = '0;
        e.st = st[3:0];
        e.alu_op = 4'b0010;
        case (st)
            0: begin e.mem_rd = 1; e.ir_wr = 1; e.src_b = 2'b01; e.pc_en = 1; end
            1: begin
                e.src_b = 2'b11;
                e.illegal = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                              op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
            end
            2: begin e.src_a = 1; e.src_b = 2'b10; end
            3: begin e.mem_rd = 1; e.iord = 1; end
            4: begin e.reg_wr = 1; e.mem_to_reg = 1; end
            5: begin e.mem_wr = 1; e.iord = 1; end
            6: begin
                e.src_a = 1;
                if (fn == 6'b100010) e.alu_op = 4'b0110;
                else if (fn == 6'b100100) e.alu_op = 4'b0000;
                else if (fn == 6'b100101) e.alu_op = 4'b0001;
                else if (fn == 6'b101010) e.alu_op = 4'b0111;
                else if (fn == 6'b100111) e.alu_op = 4'b1100;
            end
            7: begin e.reg_wr = 1; e.reg_dst = 1; end
            8: begin e.src_a = 1; e.alu_op = 4'b0110; e.pc_src = 2'b01; e.pc_en = z; end
            9: begin e.pc_src = 2'b10; e.pc_en = 1; end
            10: begin e.src_a = 1; e.src_b = 2'b10; end
            11: e.reg_wr = 1;
            default: ;
        endcase
        return e;
    endfunction

    // Entered just after a falling edge with the DUT in FETCH; leaves it in FETCH again.
    task automatic run_instr(input string name, input logic [5:0] op,
                             input logic [5:0] fn, input logic z);
        int seq[$];
        obs_t exp_o;
        obs_t act_o;
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 10, 11};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 9};
            default:   seq = '{0, 1};
        endcase
        foreach (seq[k]) sb.push_back(model(seq[k], op, fn, z));
        opcode = op;
        funct  = fn;
        zero   = z;
        #1;
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            exp_o = sb.pop_front();
            act_o = sample();
            n_checks++;
            if (act_o !== exp_o) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got %h required %h", name, i, act_o, exp_o);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_quiet(input string name);
        n_checks++;
        if ({pcEn, memRead, memWrite, irWrite, regWrite, illegalOp} !== 6'b0) begin
            n_errors++;
            $display("FAIL %s: strobes got %b required 000000", name,
                     {pcEn, memRead, memWrite, irWrite, regWrite, illegalOp});
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b100000;
        zero   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset_hold");
        n_checks++;
        if (state !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %0d required 0", state);
        end
        reset = 1'b0;
        @(negedge clk);
        // The cycle after release was FETCH, so this one is DECODE on an R-type.
        #1;
        n_checks++;
        if (state !== 4'd1) begin
            n_errors++;
            $display("FAIL reset_release: got state %0d required 1", state);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        opcode = 6'b101011;
        zero   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (state !== 4'd5 || memWrite !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_pre: got state %0d memWrite %b required 5 1", state, memWrite);
        end
        reset = 1'b1;
        #1;
        check_quiet("mid_reset_same_cycle");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check_quiet("mid_reset_hold");
            n_checks++;
            if (state !== 4'd0) begin
                n_errors++;
                $display("FAIL mid_reset_state: got %0d required 0", state);
            end
        end
        reset  = 1'b0;
        opcode = 6'b000010;
        #1;
        n_checks++;
        if (state !== 4'd0 || pcEn !== 1'b1 || irWrite !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_release: got state %0d pcEn %b irWrite %b required 0 1 1",
                     state, pcEn, irWrite);
        end
        run_instr("mid_then_j", 6'b000010, 6'b000000, 1'b0);
    endtask

    task automatic test_lw();
        run_instr("lw", 6'b100011, 6'b000000, 1'b0);
    endtask

    task automatic test_rtype();
        logic [5:0] fns [7];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b111111};
        foreach (fns[k]) run_instr("rtype", 6'b000000, fns[k], 1'b0);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1);
        run_instr("beq_not_taken", 6'b000100, 6'b000000, 1'b0);
    endtask

    task automatic test_sw_j();
        run_instr("sw", 6'b101011, 6'b000000, 1'b0);
        run_instr("j", 6'b000010, 6'b000000, 1'b0);
    endtask

    task automatic test_addi();
        run_instr("addi", 6'b001000, 6'b000000, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_ff", 6'b111111, 6'b000000, 1'b0);
        run_instr("illegal_01", 6'b000001, 6'b000000, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_lw", 6'b100011, 6'b000000, 1'b0);
        run_instr("b2b_slt", 6'b000000, 6'b101010, 1'b0);
        run_instr("b2b_beq", 6'b000100, 6'b000000, 1'b1);
        run_instr("b2b_ill", 6'b010000, 6'b000000, 1'b0);
        run_instr("b2b_addi", 6'b001000, 6'b000000, 1'b1);
        run_instr("b2b_sw", 6'b101011, 6'b000000, 1'b1);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_j();
        test_addi();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
